// File: rtl/price_pkg.sv
// Shared price-table package: unit prices in cents, FSM state encoding and the
// all-ones sentinel driven on PRICE/PRICE_BCD for reset and invalid product IDs.
package price_pkg;

  localparam int PRICE_TABLE_LEN = 12;

  localparam logic [9:0] UNIT_PRICE_TABLE [PRICE_TABLE_LEN] = '{
    10'd250, 10'd50,  10'd75,  10'd200, 10'd100, 10'd995,
    10'd695, 10'd325, 10'd275, 10'd495, 10'd425, 10'd595
  };

  localparam logic [63:0] ERR_SENTINEL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // IDs past the end of the table read as 0; the caller flags them as errors.
  function automatic logic [31:0] unit_price(input logic [31:0] id);
    unit_price = '0;
    for (int i = 0; i < PRICE_TABLE_LEN; i++) begin
      if (id == 32'(i)) unit_price = 32'(UNIT_PRICE_TABLE[i]);
    end
  endfunction

endpackage

// File: rtl/line_price_calc_if.sv
// Request/response bus of the line price engine. PRICE_BCD exists only when
// PRICE_BCD_EN is defined.
interface line_price_calc_if #(
  parameter int ID_W    = 4,
  parameter int QTT_W   = 4,
  parameter int PRICE_W = 14
`ifdef PRICE_BCD_EN
  , parameter int BCD_DIGITS = 5
`endif
);

  // Both channels are valid/ready: a transfer happens on a rising clock edge
  // where valid and ready are both 1; a raised valid holds its payload until then.
  logic               REQ_VALID;
  logic               REQ_READY;
  logic [ID_W-1:0]    ID;
  logic [QTT_W-1:0]   QTT;
  logic               RSP_VALID;
  logic               RSP_READY;
  logic [PRICE_W-1:0] PRICE;
  logic               ERR;
`ifdef PRICE_BCD_EN
  logic [4*BCD_DIGITS-1:0] PRICE_BCD;
`endif

  modport master (
    output REQ_VALID, ID, QTT, RSP_READY,
    input  REQ_READY, RSP_VALID, PRICE, ERR
`ifdef PRICE_BCD_EN
    , input PRICE_BCD
`endif
  );

  modport slave (
    input  REQ_VALID, ID, QTT, RSP_READY,
    output REQ_READY, RSP_VALID, PRICE, ERR
`ifdef PRICE_BCD_EN
    , output PRICE_BCD
`endif
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per cycle for PRICE_W cycles.
// done is high during the last shift cycle and bcd already shows the post-shift value.
module bin2bcd_seq #(
  parameter int PRICE_W    = 14,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    start,
  input  logic [PRICE_W-1:0]      bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(PRICE_W + 1);

  logic [PRICE_W-1:0]      bin_sr;
  logic [4*BCD_DIGITS-1:0] bcd_sr;
  logic [4*BCD_DIGITS-1:0] bcd_adj;
  logic [CNT_W-1:0]        cnt;
  logic                    busy;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    end
  end

  assign bcd  = (bcd_adj << 1) | {{(4*BCD_DIGITS-1){1'b0}}, bin_sr[PRICE_W-1]};
  assign done = busy && (cnt == CNT_W'(1));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bin_sr <= '0;
      bcd_sr <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      bin_sr <= bin;
      bcd_sr <= '0;
      cnt    <= CNT_W'(PRICE_W);
      busy   <= 1'b1;
    end else if (busy) begin
      bin_sr <= bin_sr << 1;
      bcd_sr <= bcd;
      cnt    <= cnt - CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/line_price_calc.sv
// Line-item price engine: table lookup, LSB-first shift-add multiply, optional
// BCD conversion when PRICE_BCD_EN is defined. One request in flight at a time.
module line_price_calc
  import price_pkg::*;
#(
  parameter int N_PRODUCTS = 12,
  parameter int ID_W       = 4,
  parameter int QTT_W      = 4,
  parameter int UNIT_W     = 10,
  parameter int PRICE_W    = 14
`ifdef PRICE_BCD_EN
  , parameter int BCD_DIGITS = 5
`endif
) (
  input  logic              CLK,
  input  logic              RESET_N,
  line_price_calc_if.slave  bus,
  output state_t            state_dbg
);

  localparam int CNT_W = $clog2(QTT_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(QTT_W - 1);

  state_t             state;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic               err_q;
  logic [PRICE_W-1:0] price_q;
  logic [PRICE_W-1:0] acc_q;
  logic [PRICE_W-1:0] mcand_q;
  logic [PRICE_W-1:0] acc_nxt;
  logic [QTT_W-1:0]   qtt_sr;
  logic [CNT_W-1:0]   bit_cnt;
  logic [ID_W-1:0]    id_req;
  logic [UNIT_W-1:0]  unit_req;
  logic               id_bad;
  logic               req_fire;
  logic               mul_last;

  assign id_req   = bus.ID;
  assign id_bad   = 32'(id_req) >= 32'(N_PRODUCTS);
  assign unit_req = UNIT_W'(unit_price(32'(id_req)));
  assign req_fire = (state == ST_IDLE) && req_ready_q && bus.REQ_VALID;
  assign mul_last = (state == ST_MUL) && (bit_cnt == LAST_BIT);
  // The accumulator is PRICE_W wide, so the add wraps modulo 2^PRICE_W.
  assign acc_nxt  = acc_q + (qtt_sr[0] ? mcand_q : '0);

  assign bus.REQ_READY = req_ready_q;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.PRICE     = price_q;
  assign bus.ERR       = err_q;
  assign state_dbg     = state;

`ifdef PRICE_BCD_EN
  logic [4*BCD_DIGITS-1:0] bcd_q;
  logic [4*BCD_DIGITS-1:0] bcd_res;
  logic                    bcd_done;

  // Launched with the final accumulator value during the last multiply cycle.
  bin2bcd_seq #(
    .PRICE_W    (PRICE_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_bin2bcd (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .start   (mul_last),
    .bin     (acc_nxt),
    .done    (bcd_done),
    .bcd     (bcd_res)
  );

  assign bus.PRICE_BCD = bcd_q;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      price_q     <= ERR_SENTINEL[PRICE_W-1:0];
      acc_q       <= '0;
      mcand_q     <= '0;
      qtt_sr      <= '0;
      bit_cnt     <= '0;
`ifdef PRICE_BCD_EN
      bcd_q       <= ERR_SENTINEL[4*BCD_DIGITS-1:0];
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_fire) begin
            req_ready_q <= 1'b0;
            acc_q       <= '0;
            if (id_bad) begin
              state       <= ST_DONE;
              rsp_valid_q <= 1'b1;
              err_q       <= 1'b1;
              price_q     <= ERR_SENTINEL[PRICE_W-1:0];
`ifdef PRICE_BCD_EN
              bcd_q       <= ERR_SENTINEL[4*BCD_DIGITS-1:0];
`endif
            end else begin
              state   <= ST_MUL;
              mcand_q <= PRICE_W'(unit_req);
              qtt_sr  <= bus.QTT;
              bit_cnt <= '0;
            end
          end
        end

        ST_MUL: begin
          acc_q   <= acc_nxt;
          mcand_q <= mcand_q << 1;
          qtt_sr  <= qtt_sr >> 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (mul_last) begin
`ifdef PRICE_BCD_EN
            state       <= ST_CONV;
`else
            state       <= ST_DONE;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b0;
            price_q     <= acc_nxt;
`endif
          end
        end

        ST_CONV: begin
`ifdef PRICE_BCD_EN
          if (bcd_done) begin
            state       <= ST_DONE;
            rsp_valid_q <= 1'b1;
            err_q       <= 1'b0;
            price_q     <= acc_q;
            bcd_q       <= bcd_res;
          end
`else
          state <= ST_IDLE;
`endif
        end

        ST_DONE: begin
          if (bus.RSP_READY) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_price_calc.sv
// Directed and randomized bench for line_price_calc against an arithmetic price model.
// Builds with or without PRICE_BCD_EN.
module tb_line_price_calc;
  import price_pkg::*;

  localparam int N_PRODUCTS = 12;
  localparam int ID_W       = 4;
  localparam int QTT_W      = 4;
  localparam int UNIT_W     = 10;
  localparam int PRICE_W    = 14;
`ifdef PRICE_BCD_EN
  localparam int BCD_DIGITS = 5;
  localparam int LAT_VALID  = QTT_W + PRICE_W + 1;
  localparam int EXP_W      = 1 + 4*BCD_DIGITS + PRICE_W;
`else
  localparam int LAT_VALID  = QTT_W + 1;
  localparam int EXP_W      = 1 + PRICE_W;
`endif
  localparam int BUDGET = 200;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t state_dbg;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  line_price_calc_if #(
    .ID_W(ID_W), .QTT_W(QTT_W), .PRICE_W(PRICE_W)
`ifdef PRICE_BCD_EN
    , .BCD_DIGITS(BCD_DIGITS)
`endif
  ) bus ();

  line_price_calc #(
    .N_PRODUCTS(N_PRODUCTS), .ID_W(ID_W), .QTT_W(QTT_W), .UNIT_W(UNIT_W), .PRICE_W(PRICE_W)
`ifdef PRICE_BCD_EN
    , .BCD_DIGITS(BCD_DIGITS)
`endif
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [EXP_W-1:0] exp_q[$];
  int unsigned ref_unit [12] = '{250, 50, 75, 200, 100, 995, 695, 325, 275, 495, 425, 595};

  // Expected {ERR, PRICE_BCD, PRICE}: product modulo 2^PRICE_W, decimal digits by division.
  function automatic logic [EXP_W-1:0] model(input int id, input int qtt);
    logic [EXP_W-1:0] r;
    int unsigned p;
    r = '1;
    if (id < N_PRODUCTS) begin
      p = (ref_unit[id] * qtt) % (1 << PRICE_W);
      r = '0;
      r[PRICE_W-1:0] = PRICE_W'(p);
`ifdef PRICE_BCD_EN
      for (int d = 0; d < BCD_DIGITS; d++) begin
        r[PRICE_W + 4*d +: 4] = 4'(p % 10);
        p = p / 10;
      end
`endif
    end
    return r;
  endfunction

  function automatic logic [EXP_W-1:0] observed();
`ifdef PRICE_BCD_EN
    return {bus.ERR, bus.PRICE_BCD, bus.PRICE};
`else
    return {bus.ERR, bus.PRICE};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns on the falling edge one cycle after the handshake edge.
  task automatic send_req(input int id, input int qtt);
    int n;
    n = 0;
    @(negedge clk);
    bus.REQ_VALID = 1'b1;
    bus.ID        = ID_W'(id);
    bus.QTT       = QTT_W'(qtt);
    while (!bus.REQ_READY && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 64'(bus.REQ_READY), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    bus.ID        = ID_W'($urandom);
    bus.QTT       = QTT_W'($urandom);
  endtask

  task automatic get_rsp(input string tag, input int exp_lat, input int delay);
    int lat;
    logic [EXP_W-1:0] e;
    lat = 1;
    while (!bus.RSP_VALID && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_valid"}, 64'(bus.RSP_VALID), 64'd1);
    if (!bus.RSP_VALID) return;
    if (exp_lat > 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    for (int i = 0; i < delay; i++) begin
      check({tag, "_hold"}, 64'(observed()), 64'(e));
      check({tag, "_hold_rdy"}, 64'(bus.REQ_READY), 64'd0);
      check({tag, "_hold_vld"}, 64'(bus.RSP_VALID), 64'd1);
      @(negedge clk);
    end
    check(tag, 64'(observed()), 64'(e));
    bus.RSP_READY = 1'b1;
    @(negedge clk);
    bus.RSP_READY = 1'b0;
    check({tag, "_ack_vld"}, 64'(bus.RSP_VALID), 64'd0);
    check({tag, "_ack_rdy"}, 64'(bus.REQ_READY), 64'd1);
    check({tag, "_kept"}, 64'(observed()), 64'(e));
  endtask

  task automatic run_req(input string tag, input int id, input int qtt, input int delay);
    exp_q.push_back(model(id, qtt));
    send_req(id, qtt);
    get_rsp(tag, (id < N_PRODUCTS) ? LAT_VALID : 1, delay);
  endtask

  // ---------------- stimulus ----------------
  logic [EXP_W-1:0] rst_exp;
  int id_r, qtt_r, hs, nrsp, stray;

  initial begin
    bus.REQ_VALID = 1'b0;
    bus.ID        = '0;
    bus.QTT       = '0;
    bus.RSP_READY = 1'b0;
    rst_exp = '1;
    rst_exp[EXP_W-1] = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(bus.REQ_READY), 64'd0);
    check("rst_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    check("rst_outputs", 64'(observed()), 64'(rst_exp));
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 64'(bus.REQ_READY), 64'd1);

    run_req("max_product", 5, 15, 0);
    run_req("zero_qtt", 1, 0, 0);
    run_req("invalid_id", 12, 3, 0);
    run_req("backpressure", 2, 4, 10);

    // Reset during the second multiply cycle aborts the request.
    send_req(0, 9);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_rsp_valid", 64'(bus.RSP_VALID), 64'd0);
    check("abort_outputs", 64'(observed()), 64'(rst_exp));
    check("abort_req_ready", 64'(bus.REQ_READY), 64'd0);
    check("abort_state", 64'(state_dbg), 64'(ST_IDLE));
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.RSP_VALID) stray++;
    end
    check("abort_no_rsp", 64'(stray), 64'd0);
    run_req("after_abort", 0, 9, 0);

    for (int i = 0; i < 25; i++) begin
      id_r  = $urandom_range(0, 15);
      qtt_r = $urandom_range(0, 15);
      run_req("random", id_r, qtt_r, $urandom_range(0, 3));
    end

    // Back-to-back with REQ_VALID and RSP_READY held high.
    exp_q.push_back(model(4, 7));
    exp_q.push_back(model(11, 2));
    @(negedge clk);
    bus.RSP_READY = 1'b1;
    bus.REQ_VALID = 1'b1;
    bus.ID        = ID_W'(4);
    bus.QTT       = QTT_W'(7);
    hs   = 0;
    nrsp = 0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (bus.RSP_VALID) begin
        nrsp++;
        if (exp_q.size() > 0) check("b2b_rsp", 64'(observed()), 64'(exp_q.pop_front()));
      end
      if (bus.REQ_VALID && bus.REQ_READY) hs++;
      @(negedge clk);
      if (hs == 1) begin
        bus.ID  = ID_W'(11);
        bus.QTT = QTT_W'(2);
      end else if (hs >= 2) begin
        bus.REQ_VALID = 1'b0;
      end
    end
    bus.RSP_READY = 1'b0;
    check("b2b_handshakes", 64'(hs), 64'd2);
    check("b2b_responses", 64'(nrsp), 64'd2);
    check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_price_calc.md
# line_price_calc

Parametrised line-item price engine for the sale terminal. It accepts a product ID and a quantity over a valid/ready request handshake, looks up the unit price in a shared table, and multiplies with an iterative shift-add. It then returns the line total in binary, and optionally in packed BCD, over a valid/ready response handshake. It sits between the keypad/entry controller and the shopping-list display and total accumulator, and supersedes the fixed 12-product, single-cycle price calculator.

## Interface
- N_PRODUCTS, 12, number of valid product IDs (0..N_PRODUCTS-1)
- ID_W, 4, product ID width
- QTT_W, 4, quantity width (unsigned)
- UNIT_W, 10, unit-price width, in cents
- PRICE_W, 14, line-total width; must satisfy PRICE_W ≥ UNIT_W+QTT_W or the top bits of the full product
- BCD_DIGITS, 5, packed BCD digits (≥ ceil(PRICE_W·log10 2))
- CLK  in  1  clock, rising edge
- RESET_N  in  1  reset, synchronous, active-low
- REQ_VALID  in  1  request present
- REQ_READY  out  1  block can accept a request
- ID  in  ID_W  product ID, sampled on the request handshake
- QTT  in  QTT_W  quantity, sampled on the request handshake
- RSP_VALID  out  1  result available
- RSP_READY  in  1  consumer accepts the result
- PRICE  out  PRICE_W  binary line total in cents
- PRICE_BCD  out  4·BCD_DIGITS  packed BCD line total (PRICE_BCD_EN only)
- ERR  out  1  ID out of range

## Operation
- FSM states: IDLE, MUL, CONV (PRICE_BCD_EN only), DONE.
- IDLE: REQ_READY=1. On REQ_VALID&&REQ_READY, latch ID and QTT, look up the unit price, and clear the accumulator.
  - ID ≥ N_PRODUCTS: go to DONE with ERR=1, PRICE all-ones, PRICE_BCD all-ones (every digit 0xF).
  - Otherwise: go to MUL.
- MUL: runs QTT_W cycles, LSB-first shift-add. Each cycle, if the current QTT bit is 1, add the shifted unit price into the accumulator. The accumulator is PRICE_W wide and the add truncates modulo 2^PRICE_W. After the last bit, go to CONV or DONE.
- CONV: runs PRICE_W cycles of double-dabble.
  - Add 3 to each BCD digit that is ≥5, then shift left by one.
  - Go to DONE after the last shift.
- DONE: RSP_VALID=1. PRICE, PRICE_BCD and ERR are held stable until RSP_READY=1, then go to IDLE.
- REQ_READY is 0 outside IDLE; the block holds one request at a time. ID/QTT changes outside the handshake cycle are ignored.
- QTT=0 is legal and produces PRICE=0, ERR=0.
- Outputs change only on a state transition into DONE. Between responses they keep their last value.

## Timing
- Reset values:
  - REQ_READY=0 during reset, 1 from the first cycle after reset deasserts
  - RSP_VALID=0, ERR=0
  - PRICE all-ones, PRICE_BCD all-ones
  - FSM in IDLE
- Latency is counted from the handshake edge to RSP_VALID high:
  - valid ID: QTT_W+1 cycles without PRICE_BCD_EN; QTT_W+PRICE_W+1 cycles with it
  - invalid ID: 1 cycle
- If RSP_READY is already high when RSP_VALID rises, the response completes in that cycle. REQ_READY rises the next cycle.
- Minimum request spacing equals latency+1.
- Reset asserted mid-MUL or mid-CONV aborts the operation on the next edge: outputs go to their reset values and no response is issued.

## Configuration
- Macro: PRICE_BCD_EN.
- Defined: the CONV state, the BCD shift register and the PRICE_BCD port are present.
- Undefined: PRICE_BCD is omitted from the port list, CONV is skipped, and latency is reduced accordingly. PRICE and ERR behaviour is identical in both builds.

## Structure
- Shared package price_pkg:
  - unit-price table as a localparam array indexed by ID: 250, 50, 75, 200, 100, 995, 695, 325, 275, 495, 425, 595
  - state enum
  - ERR sentinel constant (all-ones)
- Sub-module bin2bcd_seq holds the iterative double-dabble converter, with start/done strobes and parameters PRICE_W and BCD_DIGITS. It is instantiated only under PRICE_BCD_EN.

## Test plan
- Max product: ID=5, QTT=15 -> PRICE=14925, PRICE_BCD=0x14925, ERR=0. RSP_VALID 5 cycles after handshake (19 with BCD).
- Zero quantity: ID=1, QTT=0 -> PRICE=0, PRICE_BCD=0x00000, ERR=0.
- Invalid ID: ID=12, QTT=3 -> 1 cycle later ERR=1, PRICE=0x3FFF, PRICE_BCD=0xFFFFF.
- Backpressure: ID=2, QTT=4, RSP_READY held 0 for 10 cycles -> PRICE=300 stable throughout, REQ_READY=0 throughout. Releasing RSP_READY completes the response, and REQ_READY=1 the next cycle.
- Reset mid-op: RESET_N low in the 2nd MUL cycle of ID=0, QTT=9 -> next edge RSP_VALID=0, PRICE=0x3FFF. A fresh request ID=0, QTT=9 then yields 2250.
- Back-to-back: REQ_VALID held high with ID=4/QTT=7 then ID=11/QTT=2, RSP_READY=1 -> responses 700 then 1190 in order, with no duplicate or lost response.
